// File: rtl/regfile_mp.sv
// Multi-port integer register file with post-reset sequential clear and a req/ack debug port.
// Optional outstanding-write scoreboard enabled by defining REGFILE_SCOREBOARD_EN.
module regfile_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NRD    = 2,
  parameter int NWR    = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NWR-1:0]           we_i,
  input  logic [NWR*ADDR_W-1:0]    waddr_i,
  input  logic [NWR*DATA_W-1:0]    wdata_i,
  input  logic [NRD*ADDR_W-1:0]    raddr_i,
  output logic [NRD*DATA_W-1:0]    rdata_o,
  input  logic                     dbg_req_i,
  input  logic                     dbg_we_i,
  input  logic [ADDR_W-1:0]        dbg_addr_i,
  input  logic [DATA_W-1:0]        dbg_wdata_i,
  output logic                     dbg_ack_o,
  output logic [DATA_W-1:0]        dbg_rdata_o,
  output logic                     init_done_o,
  input  logic                     sb_set_i,
  input  logic [ADDR_W-1:0]        sb_addr_i,
  output logic [NRD-1:0]           rd_busy_o
);

  localparam int NREG = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = '1;

  typedef enum logic {INIT, RUN} main_state_t;
  typedef enum logic {IDLE, ACK} dbg_state_t;

  main_state_t state, state_next;
  dbg_state_t  dbg_state, dbg_state_next;
  logic [ADDR_W-1:0] cnt, cnt_next;

  logic [DATA_W-1:0] regs [NREG];
  logic [ADDR_W-1:0] waddr [NWR];
  logic [DATA_W-1:0] wdata [NWR];
  logic [ADDR_W-1:0] rd_addr [NRD];
  logic [DATA_W-1:0] rd_val [NRD];
  logic [NRD-1:0]    fwd_hit;

  logic run;
  logic any_we;
  logic dbg_go;

  assign run         = (state == RUN);
  assign any_we      = |we_i;
  assign init_done_o = run;
  assign dbg_ack_o   = (dbg_state == ACK);
  // Core writes always win; the debug access only happens on a cycle with no core write.
  assign dbg_go      = (dbg_state == IDLE) && dbg_req_i && run && !any_we;

  always_comb begin
    for (int k = 0; k < NWR; k++) begin
      waddr[k] = waddr_i[k*ADDR_W +: ADDR_W];
      wdata[k] = wdata_i[k*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= INIT;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      INIT: begin
        cnt_next = cnt + 1'b1;
        if (cnt == LAST_IDX) state_next = RUN;
      end
      RUN: state_next = RUN;
      default: state_next = INIT;
    endcase
  end

  // Later ports are assigned last, so the highest-index writer wins a collision.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == INIT) begin
        regs[cnt] <= '0;
      end else begin
        for (int k = 0; k < NWR; k++) begin
          if (we_i[k] && (waddr[k] != '0)) regs[waddr[k]] <= wdata[k];
        end
        if (dbg_go && dbg_we_i && (dbg_addr_i != '0)) regs[dbg_addr_i] <= dbg_wdata_i;
      end
    end
  end

  always_comb begin
    fwd_hit = '0;
    rdata_o = '0;
    for (int p = 0; p < NRD; p++) begin
      rd_addr[p] = raddr_i[p*ADDR_W +: ADDR_W];
      rd_val[p]  = regs[rd_addr[p]];
      for (int k = 0; k < NWR; k++) begin
        if (we_i[k] && (waddr[k] == rd_addr[p])) begin
          rd_val[p]  = wdata[k];
          fwd_hit[p] = 1'b1;
        end
      end
      if (!run || (rd_addr[p] == '0)) rd_val[p] = '0;
      rdata_o[p*DATA_W +: DATA_W] = rd_val[p];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) dbg_state <= IDLE;
    else     dbg_state <= dbg_state_next;
  end

  always_comb begin
    dbg_state_next = dbg_state;
    case (dbg_state)
      IDLE:    if (dbg_go) dbg_state_next = ACK;
      ACK:     dbg_state_next = IDLE;
      default: dbg_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dbg_rdata_o <= '0;
    end else if (dbg_go && !dbg_we_i) begin
      dbg_rdata_o <= (dbg_addr_i == '0) ? '0 : regs[dbg_addr_i];
    end
  end

`ifdef REGFILE_SCOREBOARD_EN
  logic [NREG-1:0] busy;

  // A same-cycle set is applied after the clears so that it takes precedence.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
    end else begin
      if (run) begin
        for (int k = 0; k < NWR; k++) begin
          if (we_i[k]) busy[waddr[k]] <= 1'b0;
        end
      end
      if (sb_set_i && (sb_addr_i != '0)) busy[sb_addr_i] <= 1'b1;
    end
  end

  always_comb begin
    rd_busy_o = '0;
    for (int p = 0; p < NRD; p++) begin
      rd_busy_o[p] = run && (rd_addr[p] != '0) && !fwd_hit[p] && busy[rd_addr[p]];
    end
  end
`else
  logic unused_sb;

  assign unused_sb = ^{sb_set_i, sb_addr_i, fwd_hit};
  assign rd_busy_o = '0;
`endif

endmodule

// File: tb/tb_regfile_mp.sv
// Randomized scoreboard bench for regfile_mp: a stimulus process pushes expected outputs,
// a monitor process pops and compares them each cycle against the DUT.
module tb_regfile_mp;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NRD    = 2;
  localparam int NWR    = 2;
  localparam int NREG   = 2**ADDR_W;

  logic                  clk;
  logic                  rst;
  logic [NWR-1:0]        we_i;
  logic [NWR*ADDR_W-1:0] waddr_i;
  logic [NWR*DATA_W-1:0] wdata_i;
  logic [NRD*ADDR_W-1:0] raddr_i;
  logic [NRD*DATA_W-1:0] rdata_o;
  logic                  dbg_req_i;
  logic                  dbg_we_i;
  logic [ADDR_W-1:0]     dbg_addr_i;
  logic [DATA_W-1:0]     dbg_wdata_i;
  logic                  dbg_ack_o;
  logic [DATA_W-1:0]     dbg_rdata_o;
  logic                  init_done_o;
  logic                  sb_set_i;
  logic [ADDR_W-1:0]     sb_addr_i;
  logic [NRD-1:0]        rd_busy_o;

  regfile_mp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NRD(NRD), .NWR(NWR)) dut (
    .clk(clk), .rst(rst), .we_i(we_i), .waddr_i(waddr_i), .wdata_i(wdata_i),
    .raddr_i(raddr_i), .rdata_o(rdata_o), .dbg_req_i(dbg_req_i), .dbg_we_i(dbg_we_i),
    .dbg_addr_i(dbg_addr_i), .dbg_wdata_i(dbg_wdata_i), .dbg_ack_o(dbg_ack_o),
    .dbg_rdata_o(dbg_rdata_o), .init_done_o(init_done_o), .sb_set_i(sb_set_i),
    .sb_addr_i(sb_addr_i), .rd_busy_o(rd_busy_o)
  );

  typedef struct packed {
    logic                  rst;
    logic [NWR-1:0]        we;
    logic [NWR*ADDR_W-1:0] waddr;
    logic [NWR*DATA_W-1:0] wdata;
    logic [NRD*ADDR_W-1:0] raddr;
    logic                  req;
    logic                  dwe;
    logic [ADDR_W-1:0]     daddr;
    logic [DATA_W-1:0]     dwdata;
    logic                  sb_set;
    logic [ADDR_W-1:0]     sb_addr;
  } stim_t;

  typedef struct packed {
    logic [31:0]           cyc;
    logic [NRD*DATA_W-1:0] rdata;
    logic [NRD-1:0]        busy;
    logic                  ack;
    logic [DATA_W-1:0]     drdata;
    logic                  done;
  } exp_t;

  stim_t stim;
  exp_t  exp_q [$];

  logic [DATA_W-1:0] ref_mem [NREG];
  bit                ref_busy [NREG];
  int                init_left;
  bit                ack_now;
  logic [DATA_W-1:0] ref_drdata;
  bit                model_valid;
  int                cycle_no;
  int                n_cmp;
  int                n_bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs for the current cycle, from the model state and the inputs now applied.
  function automatic exp_t expectNow();
    exp_t e;
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] v;
    bit hit;
    e = '0;
    e.cyc    = 32'(cycle_no);
    e.done   = (init_left == 0);
    e.ack    = ack_now;
    e.drdata = ref_drdata;
    for (int p = 0; p < NRD; p++) begin
      ra  = stim.raddr[p*ADDR_W +: ADDR_W];
      v   = '0;
      hit = 0;
      if (e.done && ra != '0) begin
        v = ref_mem[ra];
        for (int k = 0; k < NWR; k++) begin
          if (stim.we[k] && stim.waddr[k*ADDR_W +: ADDR_W] == ra) begin
            v   = stim.wdata[k*DATA_W +: DATA_W];
            hit = 1;
          end
        end
`ifdef REGFILE_SCOREBOARD_EN
        e.busy[p] = !hit && ref_busy[ra];
`endif
      end
      e.rdata[p*DATA_W +: DATA_W] = v;
    end
    return e;
  endfunction

  // Advance the reference model across one rising edge.
  task automatic modelEdge();
    bit next_ack;
    logic [ADDR_W-1:0] wa;
    next_ack = 0;
    if (stim.rst) begin
      init_left  = NREG;
      ref_drdata = '0;
      model_valid = 1;
      for (int i = 0; i < NREG; i++) begin
        ref_mem[i]  = '0;
        ref_busy[i] = 0;
      end
    end else begin
      if (init_left > 0) begin
        init_left--;
      end else begin
        for (int k = 0; k < NWR; k++) begin
          wa = stim.waddr[k*ADDR_W +: ADDR_W];
          if (stim.we[k] && wa != '0) ref_mem[wa] = stim.wdata[k*DATA_W +: DATA_W];
          if (stim.we[k]) ref_busy[wa] = 0;
        end
        if (!ack_now && stim.req && stim.we == '0) begin
          if (stim.dwe) begin
            if (stim.daddr != '0) ref_mem[stim.daddr] = stim.dwdata;
          end else begin
            ref_drdata = (stim.daddr == '0) ? '0 : ref_mem[stim.daddr];
          end
          next_ack = 1;
        end
      end
      if (stim.sb_set && stim.sb_addr != '0) ref_busy[stim.sb_addr] = 1;
    end
    ack_now = next_ack;
  endtask

  task automatic applyStimulus();
    @(negedge clk);
    rst         = stim.rst;
    we_i        = stim.we;
    waddr_i     = stim.waddr;
    wdata_i     = stim.wdata;
    raddr_i     = stim.raddr;
    dbg_req_i   = stim.req;
    dbg_we_i    = stim.dwe;
    dbg_addr_i  = stim.daddr;
    dbg_wdata_i = stim.dwdata;
    sb_set_i    = stim.sb_set;
    sb_addr_i   = stim.sb_addr;
    if (model_valid) exp_q.push_back(expectNow());
    @(posedge clk);
    modelEdge();
    cycle_no++;
  endtask

  task automatic cmp(input string name, input int cyc, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("[TB] FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, req);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    for (int p = 0; p < NRD; p++)
      cmp($sformatf("rdata[%0d]", p), int'(e.cyc), 64'(rdata_o[p*DATA_W +: DATA_W]),
          64'(e.rdata[p*DATA_W +: DATA_W]));
    cmp("rd_busy", int'(e.cyc), 64'(rd_busy_o), 64'(e.busy));
    cmp("dbg_ack", int'(e.cyc), 64'(dbg_ack_o), 64'(e.ack));
    cmp("dbg_rdata", int'(e.cyc), 64'(dbg_rdata_o), 64'(e.drdata));
    cmp("init_done", int'(e.cyc), 64'(init_done_o), 64'(e.done));
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput(e);
      end
    end
  end

  task automatic idleInputs();
    stim.rst    = 1'b0;
    stim.we     = '0;
    stim.sb_set = 1'b0;
  endtask

  task automatic setWrite(input int k, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    stim.we[k] = 1'b1;
    stim.waddr[k*ADDR_W +: ADDR_W] = a;
    stim.wdata[k*DATA_W +: DATA_W] = d;
  endtask

  task automatic setReads(input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1);
    stim.raddr[0 +: ADDR_W]      = a0;
    stim.raddr[ADDR_W +: ADDR_W] = a1;
  endtask

  // Holds the request until the model's ack cycle, keeping port 0 busy for the first cycles.
  task automatic dbgAccess(input logic wr, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                           input int core_busy);
    stim.req    = 1'b1;
    stim.dwe    = wr;
    stim.daddr  = a;
    stim.dwdata = d;
    setReads(a, a);
    for (int i = 0; i < 20; i++) begin
      idleInputs();
      if (ack_now) begin
        stim.req = 1'b0;
        applyStimulus();
        break;
      end
      if (i < core_busy) setWrite(0, ADDR_W'(10), $urandom);
      applyStimulus();
    end
    stim.req = 1'b0;
    idleInputs();
    applyStimulus();
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) begin
      setReads(ADDR_W'($urandom_range(0, NREG-1)), ADDR_W'(5));
      applyStimulus();
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog cyc=%0d actual=running required=finished", cycle_no);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    n_cmp = 0; n_bad = 0; cycle_no = 0; model_valid = 0; ack_now = 0;
    init_left = NREG; ref_drdata = '0;
    rst = 1'b1; we_i = '0; waddr_i = '0; wdata_i = '0; raddr_i = '0;
    dbg_req_i = 1'b0; dbg_we_i = 1'b0; dbg_addr_i = '0; dbg_wdata_i = '0;
    sb_set_i = 1'b0; sb_addr_i = '0;
    stim = '0;

    stim.rst = 1'b1;
    applyStimulus();
    applyStimulus();
    idleInputs();
    runCycles(NREG + 2);

    // Preload x5, then reset with a write attempted during the clear.
    setWrite(0, ADDR_W'(5), 32'hDEADBEEF);
    applyStimulus();
    idleInputs();
    runCycles(1);
    stim.rst = 1'b1;
    applyStimulus();
    idleInputs();
    runCycles(3);
    setWrite(1, ADDR_W'(5), 32'h0BADF00D);
    applyStimulus();
    idleInputs();
    runCycles(NREG);

    // Two ports collide on x7.
    setWrite(0, ADDR_W'(7), 32'h11);
    setWrite(1, ADDR_W'(7), 32'h22);
    setReads(ADDR_W'(7), ADDR_W'(7));
    applyStimulus();
    idleInputs();
    applyStimulus();

    // x0 through core and debug.
    setWrite(1, ADDR_W'(0), 32'hFFFF);
    setReads(ADDR_W'(0), ADDR_W'(0));
    applyStimulus();
    idleInputs();
    dbgAccess(1'b1, ADDR_W'(0), 32'hFFFF, 0);
    dbgAccess(1'b0, ADDR_W'(0), 32'h0, 0);

    // Debug read stalled by core writes, then a debug write.
    setWrite(0, ADDR_W'(3), 32'hA5);
    applyStimulus();
    idleInputs();
    dbgAccess(1'b0, ADDR_W'(3), 32'h0, 3);
    dbgAccess(1'b1, ADDR_W'(9), 32'h1234, 0);
    setReads(ADDR_W'(9), ADDR_W'(3));
    applyStimulus();

    // Scoreboard set, forwarded writeback, and set+writeback in one cycle.
    stim.sb_set = 1'b1; stim.sb_addr = ADDR_W'(4);
    applyStimulus();
    idleInputs();
    setReads(ADDR_W'(4), ADDR_W'(0));
    applyStimulus();
    setWrite(1, ADDR_W'(4), 32'h44);
    applyStimulus();
    idleInputs();
    applyStimulus();
    stim.sb_set = 1'b1; stim.sb_addr = ADDR_W'(4);
    setWrite(0, ADDR_W'(4), 32'h45);
    applyStimulus();
    idleInputs();
    applyStimulus();
    applyStimulus();

    for (int c = 0; c < 3000; c++) begin
      stim.rst = ($urandom_range(0, 399) == 0);
      for (int k = 0; k < NWR; k++) begin
        stim.we[k] = ($urandom_range(0, 2) == 0);
        stim.waddr[k*ADDR_W +: ADDR_W] = ($urandom_range(0, 1) == 1) ?
          ADDR_W'($urandom_range(0, 7)) : ADDR_W'($urandom_range(0, NREG-1));
        stim.wdata[k*DATA_W +: DATA_W] = $urandom;
      end
      for (int p = 0; p < NRD; p++)
        stim.raddr[p*ADDR_W +: ADDR_W] = ($urandom_range(0, 1) == 1) ?
          ADDR_W'($urandom_range(0, 7)) : ADDR_W'($urandom_range(0, NREG-1));
      stim.sb_set  = ($urandom_range(0, 3) == 0);
      stim.sb_addr = ADDR_W'($urandom_range(0, 7));
      if (ack_now) begin
        stim.req = 1'b0;
      end else if (!stim.req && $urandom_range(0, 3) == 0) begin
        stim.req    = 1'b1;
        stim.dwe    = ($urandom_range(0, 1) == 1);
        stim.daddr  = ADDR_W'($urandom_range(0, 7));
        stim.dwdata = $urandom;
      end
      applyStimulus();
    end

    idleInputs();
    stim.req = 1'b0;
    applyStimulus();
    @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("[TB] FAIL drain actual=%0d required=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
